// File: rtl/ceespu_fetch_pkg.sv
// Shared definitions for the ceespu instruction-fetch stage.
//   ADDR_W  instruction address width (matches ceespu_pc)
//   DATA_W  instruction word width
//   NOP     value shown on O_instr whenever O_valid is low
//   fetch_slot_t  one {instruction, address} pair as held by the skid/output registers
//   upd_e         which register-update path is taken on the coming edge
package ceespu_fetch_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_slot_t;

  typedef enum logic [2:0] {
    UPD_FLUSH,      // branch: drop everything held or arriving
    UPD_FROM_SKID,  // output free, skid holds an instruction
    UPD_FROM_REQ,   // output free, imem response arriving
    UPD_DRAIN,      // output free, nothing to present
    UPD_TO_SKID,    // output blocked, park the arriving response
    UPD_HOLD        // output blocked, nothing arriving
  } upd_e;

  // Priority order matters: branch beats everything, and the skid must
  // drain before a fresh response may reach the output.
  function automatic upd_e next_update(input logic branch,
                                       input logic out_free,
                                       input logic skid_valid,
                                       input logic req_valid);
    if (branch)                  return UPD_FLUSH;
    if (out_free && skid_valid)  return UPD_FROM_SKID;
    if (out_free && req_valid)   return UPD_FROM_REQ;
    if (out_free)                return UPD_DRAIN;
    if (req_valid)               return UPD_TO_SKID;
    return UPD_HOLD;
  endfunction

endpackage

// File: rtl/ceespu_fetch_if.sv
// Fetch-stage bus: PC unit / imem / decode signals bundled in one place.
//   slave  modport: the fetch stage itself
//   master modport: the surrounding pipeline (PC unit, imem, decode)
//   I_pc         fetch address from ceespu_pc
//   I_branch     branch taken this cycle
//   I_stall      decode cannot accept O_instr
//   I_imem_data  imem read data, valid the cycle after O_imem_en
//   O_imem_addr  imem address (= I_pc)
//   O_imem_en    imem read enable
//   O_pc_stall   hold ceespu_pc
//   O_instr      instruction to decode
//   O_instr_pc   address of O_instr
//   O_valid      O_instr/O_instr_pc valid
interface ceespu_fetch_if;
  import ceespu_fetch_pkg::*;

  logic [ADDR_W-1:0] I_pc;
  logic              I_branch;
  logic              I_stall;
  logic [DATA_W-1:0] I_imem_data;
  logic [ADDR_W-1:0] O_imem_addr;
  logic              O_imem_en;
  logic              O_pc_stall;
  logic [DATA_W-1:0] O_instr;
  logic [ADDR_W-1:0] O_instr_pc;
  logic              O_valid;

  modport slave (
    input  I_pc, I_branch, I_stall, I_imem_data,
    output O_imem_addr, O_imem_en, O_pc_stall, O_instr, O_instr_pc, O_valid
  );

  modport master (
    output I_pc, I_branch, I_stall, I_imem_data,
    input  O_imem_addr, O_imem_en, O_pc_stall, O_instr, O_instr_pc, O_valid
  );

endinterface

// File: rtl/ceespu_fetch.sv
// ceespu_fetch: instruction-fetch stage between ceespu_pc and decode.
// Issues one imem read per PC advance, tracks the read in flight, and
// presents {instruction, PC} to decode with a valid/stall handshake.
// A 1-entry skid register catches the response that is already in flight
// when decode stalls; the PC unit is held while the skid is occupied.
// Ports:
//   I_clk  clock, all state updates on posedge
//   I_rst  synchronous, active-high reset
//   bus    ceespu_fetch_if.slave (PC, imem and decode signals)
module ceespu_fetch
  import ceespu_fetch_pkg::*;
(
  input  logic            I_clk,
  input  logic            I_rst,
  ceespu_fetch_if.slave   bus
);

  // Read in flight: issued last cycle, data arrives on I_imem_data now.
  logic              req_valid;
  logic [ADDR_W-1:0] req_pc;

  // Skid register.
  logic              skid_valid;
  fetch_slot_t       skid;

  // Output register.
  logic              out_valid;
  fetch_slot_t       out;

  logic              pc_stall;
  logic              imem_en;
  logic              out_free;
  fetch_slot_t       resp;
  upd_e              upd;

  always_comb begin
    pc_stall = skid_valid | (out_valid & bus.I_stall);
    imem_en  = ~I_rst & ~pc_stall & ~bus.I_branch;
    out_free = ~out_valid | ~bus.I_stall;
    resp     = '{instr: bus.I_imem_data, pc: req_pc};
    upd      = next_update(bus.I_branch, out_free, skid_valid, req_valid);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain req -> out in one edge.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      // NOTE: the data fields are cleared too so O_instr/O_instr_pc come out
      // of reset at known values (NOP / 0) rather than stale contents.
      req_valid  <= 1'b0;
      req_pc     <= '0;
      skid_valid <= 1'b0;
      skid       <= '0;
      out_valid  <= 1'b0;
      out        <= '{instr: NOP, pc: '0};
    end else begin
      req_valid <= imem_en;
      req_pc    <= bus.I_pc;
      unique case (upd)
        UPD_FLUSH: begin
          // imem_en is already low during a branch, so the in-flight read
          // (arriving now) is simply never captured.
          req_valid  <= 1'b0;
          skid_valid <= 1'b0;
          out_valid  <= 1'b0;
          out.instr  <= NOP;
        end
        UPD_FROM_SKID: begin
          out        <= skid;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end
        UPD_FROM_REQ: begin
          out       <= resp;
          out_valid <= 1'b1;
        end
        UPD_DRAIN: begin
          out_valid <= 1'b0;
          out.instr <= NOP;
        end
        UPD_TO_SKID: begin
          skid       <= resp;
          skid_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.O_imem_addr = bus.I_pc;
  assign bus.O_imem_en   = imem_en;
  assign bus.O_pc_stall  = pc_stall;
  assign bus.O_instr     = out.instr;
  assign bus.O_instr_pc  = out.pc;
  assign bus.O_valid     = out_valid;

  // The PC is held while the skid is full, so no read can be in flight then.
  a_skid_req_exclusive: assert property (
    @(posedge I_clk) disable iff (I_rst) !(skid_valid && req_valid));

  // A response must never be parked on top of an occupied skid.
  a_no_skid_overflow: assert property (
    @(posedge I_clk) disable iff (I_rst) !(upd == UPD_TO_SKID && skid_valid));

endmodule

// File: tb/tb_ceespu_fetch.sv
// Directed + randomized bench for ceespu_fetch. Includes a behavioural
// ceespu_pc (resets to -1, presents PC+1, loads target on branch, holds on
// O_pc_stall) and a 1-cycle-latency imem whose word at address a is word(a).
module tb_ceespu_fetch;
  import ceespu_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ceespu_fetch_if bus ();

  ceespu_fetch dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] br_target = '0;

  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 ^ {7'd0, a};
  endfunction

  // PC unit model.
  always @(posedge clk) begin
    if (rst)                  pc_q <= '1;
    else if (bus.I_branch)    pc_q <= br_target;
    else if (!bus.O_pc_stall) pc_q <= pc_q + 1'b1;
  end
  assign bus.I_pc = pc_q + 25'd1;

  // Synchronous imem model.
  always @(posedge clk) begin
    if (bus.O_imem_en) bus.I_imem_data <= word(bus.O_imem_addr);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_en(input string tag, input logic exp_en, input logic [ADDR_W-1:0] exp_addr);
    check({tag, ".imem_en"}, 64'(bus.O_imem_en), 64'(exp_en));
    if (exp_en) check({tag, ".imem_addr"}, 64'(bus.O_imem_addr), 64'(exp_addr));
  endtask

  task automatic chk_out(input string tag, input logic exp_valid, input logic [ADDR_W-1:0] exp_pc);
    check({tag, ".valid"}, 64'(bus.O_valid), 64'(exp_valid));
    if (exp_valid) begin
      check({tag, ".instr_pc"}, 64'(bus.O_instr_pc), 64'(exp_pc));
      check({tag, ".instr"}, 64'(bus.O_instr), 64'(word(exp_pc)));
    end else begin
      check({tag, ".nop"}, 64'(bus.O_instr), 64'(NOP));
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    check({tag, ".pc_stall"}, 64'(bus.O_pc_stall), 64'(exp));
  endtask

  logic [ADDR_W-1:0] exp_next;
  int delivered;

  initial begin
    bus.I_branch = 1'b0;
    bus.I_stall  = 1'b0;

    // ---- reset ----
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk_en("rst", 1'b0, '0);
      chk_out("rst", 1'b0, '0);
      check("rst.instr_pc", 64'(bus.O_instr_pc), 64'd0);
      chk_stall("rst", 1'b0);
    end

    tick(); rst = 1'b0; #1;
    chk_en("boot0", 1'b1, 25'd0);  chk_out("boot0", 1'b0, '0);
    tick(); #1;
    chk_en("boot1", 1'b1, 25'd1);  chk_out("boot1", 1'b0, '0);
    tick(); #1;
    chk_out("A0", 1'b1, 25'd0);    chk_en("A0", 1'b1, 25'd2);

    // ---- stall 3 cycles on A1 ----
    tick(); bus.I_stall = 1'b1; #1;
    chk_out("A1s0", 1'b1, 25'd1);  chk_stall("A1s0", 1'b1);  chk_en("A1s0", 1'b0, '0);
    tick(); #1;
    chk_out("A1s1", 1'b1, 25'd1);  chk_stall("A1s1", 1'b1);  chk_en("A1s1", 1'b0, '0);
    tick(); #1;
    chk_out("A1s2", 1'b1, 25'd1);  chk_stall("A1s2", 1'b1);  chk_en("A1s2", 1'b0, '0);
    tick(); bus.I_stall = 1'b0; #1;
    chk_out("A1rel", 1'b1, 25'd1); chk_stall("A1rel", 1'b1); chk_en("A1rel", 1'b0, '0);
    tick(); #1;
    chk_out("A2skid", 1'b1, 25'd2); chk_stall("A2skid", 1'b0); chk_en("A2skid", 1'b1, 25'd3);
    tick(); #1;
    chk_out("bubble", 1'b0, '0);
    tick(); #1;
    chk_out("A3", 1'b1, 25'd3);

    // ---- branch while pc 5 in flight ----
    tick(); bus.I_branch = 1'b1; br_target = 25'h40; #1;
    chk_out("A4", 1'b1, 25'd4);    chk_en("br", 1'b0, '0);
    tick(); bus.I_branch = 1'b0; #1;
    chk_out("br+1", 1'b0, '0);     chk_en("br+1", 1'b1, 25'h41);
    tick(); #1;
    chk_out("br+2", 1'b0, '0);
    tick(); bus.I_stall = 1'b1; #1;
    chk_out("B41", 1'b1, 25'h41);  chk_stall("B41", 1'b1);    chk_en("B41", 1'b0, '0);

    // ---- branch during stall with skid full ----
    tick(); bus.I_branch = 1'b1; br_target = 25'h80; #1;
    chk_out("skidfull", 1'b1, 25'h41); chk_stall("skidfull", 1'b1); chk_en("skidbr", 1'b0, '0);
    tick(); bus.I_branch = 1'b0; #1;
    chk_out("skidbr+1", 1'b0, '0); chk_stall("skidbr+1", 1'b0); chk_en("skidbr+1", 1'b1, 25'h81);
    tick(); bus.I_stall = 1'b0; #1;
    chk_out("skidbr+2", 1'b0, '0);
    tick(); #1;
    chk_out("C81", 1'b1, 25'h81);
    tick(); bus.I_stall = 1'b1; #1;
    chk_out("C82", 1'b1, 25'h82);  chk_en("C82", 1'b0, '0);

    // ---- reset mid-stream with skid full ----
    tick(); rst = 1'b1; #1;
    chk_stall("prerst", 1'b1);     chk_en("midrst", 1'b0, '0);
    tick(); rst = 1'b0; bus.I_stall = 1'b0; #1;
    chk_out("rst2", 1'b0, '0);     chk_stall("rst2", 1'b0);   chk_en("rst2", 1'b1, 25'd0);
    tick(); #1;
    chk_out("rst2+1", 1'b0, '0);
    tick(); #1;
    chk_out("rst2A0", 1'b1, 25'd0);

    // ---- random stall/branch against the in-order scoreboard ----
    exp_next  = 25'd1;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      bus.I_stall  = ($urandom_range(0, 99) < 30);
      bus.I_branch = ($urandom_range(0, 99) < 4);
      br_target    = ($urandom_range(0, 3) == 0) ? 25'h1FF_FFFF : 25'($urandom);
      #1;
      if (!bus.O_valid) check("rnd.nop", 64'(bus.O_instr), 64'(NOP));
      if (bus.I_branch) begin
        exp_next = br_target + 25'd1;
      end else if (bus.O_valid && !bus.I_stall) begin
        check("rnd.pc", 64'(bus.O_instr_pc), 64'(exp_next));
        check("rnd.instr", 64'(bus.O_instr), 64'(word(exp_next)));
        exp_next = exp_next + 25'd1;
        delivered++;
      end
    end
    check("rnd.throughput", 64'(delivered > 500), 64'd1);

    bus.I_stall  = 1'b0;
    bus.I_branch = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
